sobel_stream: RTL and testbench
===============================

# sobel_stream

Parametrised streaming Sobel edge detector: the next generation of the team's fixed-size 8-bit Sobel block. It accepts a raster pixel stream with an optional start-of-frame marker and buffers two image lines in internal inferred RAM, so no external FIFO IP is needed. It computes |Gx|+|Gy| over every interior 3×3 window and emits either a thresholded binary pixel or a saturated magnitude, with an end-of-frame marker. It sits between the pixel source (UART/camera front end) and the display/output writer.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 100: pixels per line, ≥3
- IMG_H, 100: lines per frame, ≥3
- sys_clk  in  1  sole clock, rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- pi_flag  in  1  input pixel valid; one pixel per high cycle
- pi_data  in  DATA_W  input pixel
- pi_sof  in  1  qualified by pi_flag; forces this pixel to position (0,0)
- cfg_mode  in  1  0 = binary output, 1 = magnitude output
- cfg_thresh  in  DATA_W+3  binary-mode threshold
- po_flag  out  1  output pixel valid
- po_data  out  DATA_W  output pixel
- po_eof  out  1  high with po_flag on the last interior pixel of a frame

## Operation
- Column and row counters (width $clog2 of IMG_W and IMG_H) advance only on pi_flag. Column wraps at IMG_W-1 and increments row. Row wraps at IMG_H-1 on the last column.
- pi_sof with pi_flag: the pixel is treated as (0,0) and the next pixel as (0,1), regardless of counter state. pi_sof without pi_flag is ignored.
- cfg_mode and cfg_thresh are latched on the pi_flag cycle of every pixel counted as (0,0). They hold for the whole frame; mid-frame changes have no effect.
- Two line buffers of depth IMG_W hold rows r-1 and r-2 at each column. Both are updated on every pi_flag, including rows 0 and 1.
- 3×3 window columns shift only on pi_flag. Naming: a = row r-2, b = row r-1, c = row r; index 1 = column c-2, index 3 = column c.
- Gx = (a3+2b3+c3)−(a1+2b1+c1) and Gy = (a1+2a2+a3)−(c1+2c2+c3), both signed DATA_W+3 bits. |Gx|, |Gy| are DATA_W+2 bits unsigned; sum is DATA_W+3 bits. No overflow is possible.
- A window is valid when the completing pixel has r≥2 and c≥2, giving (IMG_W−2)·(IMG_H−2) outputs per frame. Border pixels produce no output.
- Mode 0: po_data = 0 (black) if sum ≥ thresh, else all-ones (white).
- Mode 1: po_data = min(sum, 2^DATA_W−1).
- po_eof is set when the completing pixel is (IMG_H−1, IMG_W−1).

## Timing
- Reset (sys_rst_n low at a rising edge) clears on the next edge:
  - po_flag=0, po_data=0, po_eof=0
  - counters=0, pipeline valid bits=0, mode=0, thresh=0
  - In-flight results are dropped. Line-buffer contents need not be cleared.
- Latency: po_flag is high exactly 4 cycles after the pi_flag cycle of the completing pixel (pi_flag at cycle T → po_flag at T+4).
  - Stage 1: line-buffer read and window shift.
  - Stage 2: Gx and Gy.
  - Stage 3: absolute values.
  - Stage 4: sum and compare/saturate, registered to outputs.
- The pipeline is flow-through and carries a valid bit per stage. Input gaps of any length never alter latency or drop data. Back-to-back pi_flag sustains one output per cycle.
- po_flag is a one-cycle pulse per output. po_data holds its value while po_flag is low. po_eof is only ever high together with po_flag.
- pi_sof arriving mid-frame does not flush results already in the pipeline; they complete with their original mode and thresh. Pixels of the aborted frame that have not completed a window produce nothing. The first output of the new frame follows its pixel (2,2).
- Stage 4 uses the mode and thresh captured for the frame that the window belongs to. The latch takes effect for pixel (0,0) itself; no interior pixel can straddle a latch.

## Test plan
- Flat frame: DATA_W=8, IMG_W=8, IMG_H=6, all pixels 0x40, mode 0, thresh 12 → 24 outputs, all 0xFF. po_eof only on output 24. Each output at T+4 from its completing pixel.
- Vertical edge: columns 0–3 = 0x00, columns 4–7 = 0xFF, mode 1 → each output row reads 00 00 FF FF 00 00 (sum 1020 saturated). po_eof on the last output.
- Horizontal ramp: pixel = 10·col, mode 1 → all outputs 0x50. Same data in mode 0 with thresh 80 → all 0x00; with thresh 81 → all 0xFF. Thresh changed mid-frame has no effect until the next (0,0).
- Gapped input: vertical-edge frame with pi_flag high 1 cycle in 3 → identical po_data sequence, each po_flag exactly 4 cycles after its completing pixel.
- Resync: pi_sof asserted on pixel 20 of a frame, then a full frame → the counter restarts at 20. Old-frame outputs already in flight complete. The next output appears 4 cycles after new pixel (2,2). The new frame gives exactly 24 outputs and one po_eof.
- Reset mid-frame: sys_rst_n low for 1 cycle while outputs are streaming → po_flag, po_data, po_eof are 0 on the next cycle and in-flight results are dropped. The first pixel after reset, without pi_sof, counts as (0,0).

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two inferred line buffers, 4-stage flow-through
// pipeline, per-frame latched mode/threshold, binary or saturated-magnitude output.
module sobel_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_sof,
    input  logic              cfg_mode,
    input  logic [DATA_W+2:0] cfg_thresh,
    output logic              po_flag,
    output logic [DATA_W-1:0] po_data,
    output logic              po_eof
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int GW    = DATA_W + 3;
    localparam int AW    = DATA_W + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // raster position and frame configuration
    logic [COL_W-1:0] col_reg, pos_col, col_next;
    logic [ROW_W-1:0] row_reg, pos_row, row_next;
    logic             mode_reg;
    logic [GW-1:0]    thresh_reg;
    logic             at_origin, interior, last_px;

    always_comb begin
        pos_col  = pi_sof ? '0 : col_reg;
        pos_row  = pi_sof ? '0 : row_reg;
        col_next = pos_col + COL_W'(1);
        row_next = pos_row;
        if (pos_col == COL_LAST) begin
            col_next = '0;
            row_next = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
        end
    end

    assign at_origin = (pos_col == '0) && (pos_row == '0);
    assign interior  = (pos_col >= COL_TWO) && (pos_row >= ROW_TWO);
    assign last_px   = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            col_reg    <= '0;
            row_reg    <= '0;
            mode_reg   <= 1'b0;
            thresh_reg <= '0;
        end else if (pi_flag) begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (at_origin) begin
                mode_reg   <= cfg_mode;
                thresh_reg <= cfg_thresh;
            end
        end
    end

    // lb1 holds row r-1, lb2 holds row r-2; lb2 is refilled one cycle late from the lb1 read
    logic [DATA_W-1:0] lb1_mem [0:IMG_W-1];
    logic [DATA_W-1:0] lb2_mem [0:IMG_W-1];
    logic [DATA_W-1:0] rd_a_reg, rd_b_reg, pix_reg;
    logic [2:0][DATA_W-1:0] col1_reg, col2_reg, col3;
    logic             wb_en_reg;
    logic [COL_W-1:0] wb_addr_reg;

    assign col3 = {pix_reg, rd_b_reg, rd_a_reg};

    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            rd_a_reg         <= lb2_mem[pos_col];
            rd_b_reg         <= lb1_mem[pos_col];
            lb1_mem[pos_col] <= pi_data;
            pix_reg          <= pi_data;
            col2_reg         <= col3;
            col1_reg         <= col2_reg;
        end
        if (wb_en_reg) begin
            lb2_mem[wb_addr_reg] <= rd_b_reg;
        end
    end

    // window taps: index 0 = row a (r-2), 1 = row b (r-1), 2 = row c (r)
    logic [DATA_W-1:0] a1, a2, a3, b1, b3, c1, c2, c3;
    assign a1 = col1_reg[0];
    assign a2 = col2_reg[0];
    assign a3 = col3[0];
    assign b1 = col1_reg[1];
    assign b3 = col3[1];
    assign c1 = col1_reg[2];
    assign c2 = col2_reg[2];
    assign c3 = col3[2];

    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] x);
        return GW'(x);
    endfunction

    logic [GW-1:0] gx_next, gy_next, sum_next;
    logic [AW-1:0] ax_next, ay_next;
    logic [DATA_W-1:0] out_next;

    // pipeline registers
    logic             s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic             s1_eof_reg, s2_eof_reg, s3_eof_reg;
    logic             s1_mode_reg, s2_mode_reg, s3_mode_reg;
    logic [GW-1:0]    s1_thresh_reg, s2_thresh_reg, s3_thresh_reg;
    logic [GW-1:0]    gx_reg, gy_reg;
    logic [AW-1:0]    ax_reg, ay_reg;

    always_comb begin
        gx_next = (ext(a3) + (ext(b3) << 1) + ext(c3)) - (ext(a1) + (ext(b1) << 1) + ext(c1));
        gy_next = (ext(a1) + (ext(a2) << 1) + ext(a3)) - (ext(c1) + (ext(c2) << 1) + ext(c3));
        ax_next = gx_reg[GW-1] ? AW'(-gx_reg) : AW'(gx_reg);
        ay_next = gy_reg[GW-1] ? AW'(-gy_reg) : AW'(gy_reg);
        sum_next = GW'(ax_reg) + GW'(ay_reg);
        if (s3_mode_reg) begin
            out_next = (|sum_next[GW-1:DATA_W]) ? '1 : sum_next[DATA_W-1:0];
        end else begin
            out_next = (sum_next >= s3_thresh_reg) ? '0 : '1;
        end
    end

    // config travels with each window so a resync never re-targets results in flight
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wb_en_reg     <= 1'b0;
            wb_addr_reg   <= '0;
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s3_valid_reg  <= 1'b0;
            s1_eof_reg    <= 1'b0;
            s2_eof_reg    <= 1'b0;
            s3_eof_reg    <= 1'b0;
            s1_mode_reg   <= 1'b0;
            s2_mode_reg   <= 1'b0;
            s3_mode_reg   <= 1'b0;
            s1_thresh_reg <= '0;
            s2_thresh_reg <= '0;
            s3_thresh_reg <= '0;
            gx_reg        <= '0;
            gy_reg        <= '0;
            ax_reg        <= '0;
            ay_reg        <= '0;
            po_flag       <= 1'b0;
            po_data       <= '0;
            po_eof        <= 1'b0;
        end else begin
            wb_en_reg    <= pi_flag;
            if (pi_flag) begin
                wb_addr_reg   <= pos_col;
                s1_mode_reg   <= mode_reg;
                s1_thresh_reg <= thresh_reg;
            end
            s1_valid_reg  <= pi_flag && interior;
            s1_eof_reg    <= pi_flag && last_px;

            s2_valid_reg  <= s1_valid_reg;
            s2_eof_reg    <= s1_eof_reg;
            s2_mode_reg   <= s1_mode_reg;
            s2_thresh_reg <= s1_thresh_reg;
            gx_reg        <= gx_next;
            gy_reg        <= gy_next;

            s3_valid_reg  <= s2_valid_reg;
            s3_eof_reg    <= s2_eof_reg;
            s3_mode_reg   <= s2_mode_reg;
            s3_thresh_reg <= s2_thresh_reg;
            ax_reg        <= ax_next;
            ay_reg        <= ay_next;

            po_flag <= s3_valid_reg;
            po_eof  <= s3_valid_reg && s3_eof_reg;
            if (s3_valid_reg) begin
                po_data <= out_next;
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame: flat, edge, ramp, gapped,
// resync and mid-frame reset, each output checked for value, eof and latency.
module tb_sobel_stream;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam logic [47:0] ROW_FF = {6{8'hFF}};
    localparam logic [47:0] ROW_00 = 48'h0;
    localparam logic [47:0] ROW_VE = 48'h0000FFFF0000;
    localparam logic [47:0] ROW_50 = {6{8'h50}};

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          pi_flag = 1'b0;
    logic [DW-1:0] pi_data = '0;
    logic          pi_sof = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [DW+2:0] cfg_thresh = '0;
    logic          po_flag;
    logic [DW-1:0] po_data;
    logic          po_eof;

    sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pi_flag    (pi_flag),
        .pi_data    (pi_data),
        .pi_sof     (pi_sof),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .po_flag    (po_flag),
        .po_data    (po_data),
        .po_eof     (po_eof)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got_d[$], exp_d[$];
    logic       got_e[$], exp_e[$];
    int         got_c[$], exp_c[$];
    logic       hold_chk = 1'b0;
    logic [7:0] last_d = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (po_flag) begin
            got_d.push_back(po_data);
            got_e.push_back(po_eof);
            got_c.push_back(cyc);
        end else if (hold_chk) begin
            check_val("hold", 32'(po_data), 32'(last_d));
        end
        if (po_eof && !po_flag) check_val("eof_alone", 32'(po_eof), 32'd0);
        last_d = po_data;
    end

    function automatic logic [7:0] pix(input int kind, input int c);
        case (kind)
            0:       return 8'h40;
            1:       return (c < 4) ? 8'h00 : 8'hFF;
            default: return 8'(10 * c);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            pi_flag = 1'b0;
            pi_sof  = 1'b0;
        end
    endtask

    // kind: 0 flat 0x40, 1 vertical edge, 2 ramp 10*col; thr_late applies from pixel 10
    task automatic run_frame(input int kind, input logic mode, input logic [10:0] thr, input int gap,
                             input int npix, input logic sof_first, input logic [10:0] thr_late,
                             input logic [47:0] exp_row);
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            @(posedge sys_clk);
            #1;
            pi_flag    = 1'b1;
            pi_data    = pix(kind, c);
            pi_sof     = sof_first && (i == 0);
            cfg_mode   = mode;
            cfg_thresh = (i >= 10) ? thr_late : thr;
            if (r >= 2 && c >= 2) begin
                exp_d.push_back(exp_row[8*(c-2) +: 8]);
                exp_e.push_back((r == H - 1) && (c == W - 1));
                exp_c.push_back(cyc + 4);
            end
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic clear_q();
        got_d.delete(); got_e.delete(); got_c.delete();
        exp_d.delete(); exp_e.delete(); exp_c.delete();
    endtask

    task automatic drain_compare(input string tag);
        int n;
        idle(8);
        check_val($sformatf("%s.count", tag), 32'(got_d.size()), 32'(exp_d.size()));
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            $display("%s out %0d: data=%02h eof=%0b cyc=%0d (exp %02h %0b %0d)",
                     tag, i, got_d[i], got_e[i], got_c[i], exp_d[i], exp_e[i], exp_c[i]);
            check_val($sformatf("%s[%0d].data", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
            check_val($sformatf("%s[%0d].eof", tag, i), 32'(got_e[i]), 32'(exp_e[i]));
            check_val($sformatf("%s[%0d].cyc", tag, i), 32'(got_c[i]), 32'(exp_c[i]));
        end
        clear_q();
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_val("reset.flag", 32'(po_flag), 32'd0);
        check_val("reset.data", 32'(po_data), 32'd0);
        check_val("reset.eof", 32'(po_eof), 32'd0);
        idle(1);
        hold_chk = 1'b1;

        run_frame(0, 1'b0, 11'd12, 0, W*H, 1'b0, 11'd12, ROW_FF);
        drain_compare("flat");
        run_frame(1, 1'b1, 11'd0, 0, W*H, 1'b0, 11'd0, ROW_VE);
        drain_compare("vedge");
        run_frame(2, 1'b1, 11'd0, 0, W*H, 1'b0, 11'd0, ROW_50);
        drain_compare("ramp_mag");
        run_frame(2, 1'b0, 11'd80, 0, W*H, 1'b0, 11'd81, ROW_00);
        drain_compare("ramp_t80");
        run_frame(2, 1'b0, 11'd81, 0, W*H, 1'b0, 11'd81, ROW_FF);
        drain_compare("ramp_t81");
        run_frame(1, 1'b1, 11'd0, 2, W*H, 1'b0, 11'd0, ROW_VE);
        drain_compare("gapped");

        // partial magnitude frame, then sof into a binary frame back-to-back
        run_frame(1, 1'b1, 11'd0, 0, 20, 1'b0, 11'd0, ROW_VE);
        run_frame(0, 1'b0, 11'd12, 0, W*H, 1'b1, 11'd12, ROW_FF);
        drain_compare("resync");

        // reset while row-4 outputs stream; pixel (4,5) result is still in flight
        run_frame(1, 1'b1, 11'd0, 0, 38, 1'b0, 11'd0, ROW_VE);
        idle(2);
        hold_chk = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_val("pre_reset.flag", 32'(po_flag), 32'd1);
        check_val("pre_reset.data", 32'(po_data), 32'hFF);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check_val("mid_reset.flag", 32'(po_flag), 32'd0);
        check_val("mid_reset.data", 32'(po_data), 32'd0);
        check_val("mid_reset.eof", 32'(po_eof), 32'd0);
        clear_q();
        idle(6);
        check_val("mid_reset.dropped", 32'(got_d.size()), 32'd0);
        hold_chk = 1'b1;
        run_frame(0, 1'b0, 11'd12, 0, W*H, 1'b0, 11'd12, ROW_FF);
        drain_compare("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
